// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master controller.
// Contents:
//   state_t         controller FSM states (IDLE..DONE)
//   RW_WRITE/READ   encoding of the R/W bit on the bus
//   quarter_t       quarter index inside a bit slot (Q0..Q3)
//   QUARTERS_*      quarter counts of a full transaction and an address-NACK transaction
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_ACK1,
      ST_DATA,
      ST_ACK2,
      ST_STOP,
      ST_DONE
   } state_t;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef enum logic [1:0] {
      Q0,
      Q1,
      Q2,
      Q3
   } quarter_t;

   // 2 (START) + 32 (ADDR) + 4 (ACK1) + 32 (DATA) + 4 (ACK2) + 3 (STOP)
   localparam int QUARTERS_FULL      = 77;
   // 2 (START) + 32 (ADDR) + 4 (ACK1) + 3 (STOP)
   localparam int QUARTERS_ADDR_NACK = 41;

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider.
// Produces a single-clk tick every CLK_DIV clocks. The count restarts from
// zero on clear, and is held at zero while hold is high (SCL stretching).
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   clear       restart the quarter (transaction accept)
//   hold        keep the count at zero (slave stretching SCL)
//   tick        high on the last clk of each quarter
module i2c_quarter_tick #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic hold,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || hold || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = !clear && !hold && (cnt == LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address + R/W, ACK, one data byte,
// ACK/NACK, STOP. One request at a time over req_valid/req_ready, one-cycle
// response pulse on rsp_valid.
// Optional build macro: I2C_CLK_STRETCH_EN enables slave clock stretching
// through scl_in; without it scl_in is ignored.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_rw              0 write, 1 read
//   req_addr            7-bit target, 7'h00 selects DEFAULT_ADDR
//   req_wdata           byte to write
//   req_nack_last       on read, NACK the data byte when 1
//   rsp_valid           one-clk completion pulse
//   rsp_rdata           last byte read, held until the next read completes
//   rsp_ack_err         slave NACKed address or write data
//   busy                high from accept until rsp_valid
//   sclk                SCL (push-pull)
//   scl_in              SCL pin sense (stretching only)
//   sda_oe              1 pulls SDA low, 0 releases it
//   sda_in              SDA pin sense
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int         CLK_DIV      = 50,
   parameter logic [6:0] DEFAULT_ADDR = 7'h27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_wdata,
   input  logic       req_nack_last,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_ack_err,
   output logic       busy,
   output logic       sclk,
   input  logic       scl_in,
   output logic       sda_oe,
   input  logic       sda_in
);

   state_t     state, state_next;
   quarter_t   qidx;
   logic [2:0] bit_cnt;
   logic       err_r;
   logic [7:0] rdata_r;

   logic [6:0] addr_r;
   logic       rw_r;
   logic [7:0] wdata_r;
   logic       nack_r;
   logic [7:0] shift_r;

   logic       accept;
   logic       tick;
   logic       hold;
   logic       in_slot;
   logic       sample;
   logic [7:0] addr_byte;

   assign accept    = req_valid && (state == ST_IDLE);
   assign in_slot   = (state == ST_ADDR) || (state == ST_ACK1) ||
                      (state == ST_DATA) || (state == ST_ACK2);
   assign sample    = tick && in_slot && (qidx == Q2);
   assign addr_byte = {addr_r, rw_r};

`ifdef I2C_CLK_STRETCH_EN
   // Freeze the quarter while we release SCL high but the pin still reads low.
   assign hold = (in_slot || (state == ST_STOP)) && (qidx == Q1) && sclk && !scl_in;
`else
   logic scl_in_unused;
   assign scl_in_unused = scl_in;
   assign hold          = 1'b0;
`endif

   i2c_quarter_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (accept),
      .hold  (hold),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and bus/handshake outputs; outputs decode registered state
   // only, so an async reset releases the bus in the same cycle.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      busy       = 1'b0;
      rsp_valid  = 1'b0;
      sclk       = 1'b1;
      sda_oe     = 1'b0;
      if (in_slot) begin
         busy = 1'b1;
         sclk = (qidx == Q1) || (qidx == Q2);
      end
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = ST_START;
         end
         ST_START: begin
            busy   = 1'b1;
            sclk   = (qidx == Q0);
            sda_oe = 1'b1;
            if (tick && (qidx == Q1)) state_next = ST_ADDR;
         end
         ST_ADDR: begin
            sda_oe = !addr_byte[~bit_cnt];
            if (tick && (qidx == Q3) && (bit_cnt == 3'd7)) state_next = ST_ACK1;
         end
         ST_ACK1: begin
            if (tick && (qidx == Q3)) state_next = err_r ? ST_STOP : ST_DATA;
         end
         ST_DATA: begin
            sda_oe = (rw_r == RW_WRITE) && !wdata_r[~bit_cnt];
            if (tick && (qidx == Q3) && (bit_cnt == 3'd7)) state_next = ST_ACK2;
         end
         ST_ACK2: begin
            // Master response on read: SDA low means ACK.
            sda_oe = (rw_r == RW_READ) && !nack_r;
            if (tick && (qidx == Q3)) state_next = ST_STOP;
         end
         ST_STOP: begin
            busy   = 1'b1;
            sclk   = (qidx != Q0);
            sda_oe = (qidx != Q2);
            if (tick && (qidx == Q2)) state_next = ST_DONE;
         end
         ST_DONE: begin
            rsp_valid  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qidx    <= Q0;
         bit_cnt <= '0;
         err_r   <= 1'b0;
         rdata_r <= '0;
      end else begin
         if (accept || (state_next != state)) begin
            qidx    <= Q0;
            bit_cnt <= '0;
         end else if (tick) begin
            qidx <= quarter_t'(qidx + 2'd1);
            if (qidx == Q3) bit_cnt <= bit_cnt + 3'd1;
         end
         if (accept) begin
            err_r <= 1'b0;
         end else if (sample && sda_in &&
                      ((state == ST_ACK1) || ((state == ST_ACK2) && (rw_r == RW_WRITE)))) begin
            err_r <= 1'b1;
         end
         if ((state == ST_STOP) && (state_next == ST_DONE) && (rw_r == RW_READ) && !err_r) begin
            rdata_r <= shift_r;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_r  <= (req_addr == 7'h00) ? DEFAULT_ADDR : req_addr;
         rw_r    <= req_rw;
         wdata_r <= req_wdata;
         nack_r  <= req_nack_last;
      end
      if (sample && (state == ST_DATA)) begin
         shift_r <= {shift_r[6:0], sda_in};
      end
   end

   assign rsp_rdata   = rdata_r;
   assign rsp_ack_err = err_r;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a small I2C slave model on the pins.
module tb_i2c_master_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rw = 1'b0;
   logic [6:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       req_nack_last = 1'b0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_ack_err;
   logic       busy;
   logic       sclk;
   logic       scl_in;
   logic       sda_oe;
   logic       sda_in;

   // slave model state
   logic        slave_low = 1'b0;
   logic        stretch_req = 1'b0;
   logic        stretch_en = 1'b0;
   int          held = 0;
   logic        prev_scl = 1'b1;
   logic        prev_sda = 1'b1;
   int          bitpos = 0;
   logic [17:0] cap = '0;
   logic        stop_seen = 1'b0;
   logic        cfg_rw = 1'b0;
   logic        cfg_addr_nack = 1'b0;
   logic        cfg_data_nack = 1'b0;
   logic [7:0]  cfg_rdata = '0;

   int checks = 0;
   int failures = 0;

   assign sda_in = !sda_oe && !slave_low;
   assign scl_in = sclk && !stretch_req;

   i2c_master_ctrl #(
      .CLK_DIV      (D),
      .DEFAULT_ADDR (7'h27)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_rw        (req_rw),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_nack_last (req_nack_last),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_ack_err   (rsp_ack_err),
      .busy          (busy),
      .sclk          (sclk),
      .scl_in        (scl_in),
      .sda_oe        (sda_oe),
      .sda_in        (sda_in)
   );

   always #5 clk = ~clk;

   // Slave: records the line at every SCL rise, changes its drive on SCL fall.
   always @(negedge clk) begin
      logic line;
      line = sda_in;
      if (!rst_n) begin
         slave_low   = 1'b0;
         bitpos      = 0;
         stretch_req = 1'b0;
      end else begin
         if (prev_scl && sclk && prev_sda && !line) begin
            bitpos    = 0;
            slave_low = 1'b0;
         end else if (prev_scl && sclk && !prev_sda && line) begin
            stop_seen = 1'b1;
         end
         if (!prev_scl && sclk) begin
            if (bitpos < 18) cap[bitpos] = line;
            bitpos++;
         end
         if (prev_scl && !sclk) begin
            slave_low = 1'b0;
            if (bitpos == 8) slave_low = !cfg_addr_nack;
            else if (bitpos >= 9 && bitpos <= 16 && cfg_rw) slave_low = !cfg_rdata[16-bitpos];
            else if (bitpos == 17 && !cfg_rw) slave_low = !cfg_data_nack;
            if (stretch_en && bitpos == 3) stretch_req = 1'b1;
         end
         if (stretch_req && sclk) begin
            held++;
            if (held == 40) stretch_req = 1'b0;
         end
      end
      prev_scl = sclk;
      prev_sda = line;
   end

   typedef struct {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic       nack_last;
      logic       s_addr_nack;
      logic       s_data_nack;
      logic [7:0] s_rdata;
      logic [7:0] e_addr;
      logic [7:0] e_data;
      logic       e_ack2;
      logic       e_err;
      logic [7:0] e_rdata;
      int         e_rises;   // SCL rises seen, including the one inside STOP
      int         e_lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, input int extra);
      int cyc;
      logic [7:0] ab, db;
      cfg_rw        = v.rw;
      cfg_addr_nack = v.s_addr_nack;
      cfg_data_nack = v.s_data_nack;
      cfg_rdata     = v.s_rdata;
      stop_seen     = 1'b0;
      cap           = '0;
      @(negedge clk);
      req_valid     = 1'b1;
      req_rw        = v.rw;
      req_addr      = v.addr;
      req_wdata     = v.wdata;
      req_nack_last = v.nack_last;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("ready_after_accept", req_ready, 0);
      cyc = 0;
      while (cyc < 5000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (rsp_valid) break;
      end
      chk("latency", cyc, v.e_lat + extra);
      chk("ack_err", rsp_ack_err, v.e_err);
      chk("rdata", rsp_rdata, v.e_rdata);
      chk("busy_at_rsp", busy, 0);
      for (int i = 0; i < 8; i++) begin
         ab[7-i] = cap[i];
         db[7-i] = cap[9+i];
      end
      chk("addr_byte", ab, v.e_addr);
      chk("scl_rises", bitpos, v.e_rises);
      chk("stop_seen", stop_seen, 1);
      if (v.e_rises == 19) begin
         chk("data_byte", db, v.e_data);
         chk("ack2_line", cap[17], v.e_ack2);
      end
      @(posedge clk);
      #1;
      chk("ready_after_rsp", req_ready, 1);
      chk("rsp_pulse_ends", rsp_valid, 0);
   endtask

   vec_t vecs[5];

   initial begin
      //          rw    addr   wdata  nl    anak  dnak  srd    e_addr e_data ack2  err   e_rd   rises lat
      vecs[0] = '{1'b0, 7'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h4E, 8'hA5, 1'b0, 1'b0, 8'h00, 19, 77*D};
      vecs[1] = '{1'b1, 7'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 8'h96, 8'h79, 8'h96, 1'b1, 1'b0, 8'h96, 19, 77*D};
      vecs[2] = '{1'b0, 7'h50, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA0, 8'h00, 1'b0, 1'b1, 8'h96, 10, 41*D};
      vecs[3] = '{1'b0, 7'h11, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 8'h3C, 1'b1, 1'b1, 8'h96, 19, 77*D};
      vecs[4] = '{1'b1, 7'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0, 8'h5A, 19, 77*D};

      // reset values
      @(negedge clk);
      chk("rst_sclk", sclk, 1);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_ack_err", rsp_ack_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 5; i++) run_txn(vecs[i], 0);

      // asynchronous reset in the middle of the DATA phase of a write
      cfg_rw = 1'b0; cfg_addr_nack = 1'b0; cfg_data_nack = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h00; req_wdata = 8'h00; req_nack_last = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat ((2 + 32 + 4 + 12) * D) @(posedge clk);
      @(negedge clk);
      chk("busy_in_data", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_sclk", sclk, 1);
      chk("midrst_sda_oe", sda_oe, 0);
      chk("midrst_ready", req_ready, 1);
      chk("midrst_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_txn(vecs[0], 0);

`ifdef I2C_CLK_STRETCH_EN
      // slave holds SCL low for 40 clks in the fourth address slot
      held = 0;
      stretch_en = 1'b1;
      run_txn(vecs[0], 40);
      stretch_en = 1'b0;
      chk("stretch_held", held, 40);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
